// File: rtl/tick_period_monitor_pkg.sv
// Shared definitions for the tick period monitor: FSM state encoding and
// default parameter values used by the top level and the testbench.
package tick_period_monitor_pkg;

  localparam int unsigned DEF_W          = 10;
  localparam int unsigned DEF_EXPECTED   = 500;
  localparam int unsigned DEF_TOL        = 2;
  localparam int unsigned DEF_LOCK_COUNT = 4;
  localparam int unsigned DEF_TIMEOUT    = 1000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

endpackage : tick_period_monitor_pkg

// File: rtl/tick_period_monitor_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous tick plus a rising-edge pulse.
// Ports:
//   clock       in  system clock
//   reset       in  asynchronous active-high reset
//   tick_in     in  asynchronous tick pulse
//   tick_edge_c out one-cycle pulse per synchronized rising edge (combinational)
module sync_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic tick_in,
  output logic tick_edge_c
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic vld1_q;
  logic vld2_q;
  logic seen_low_q;

  // vld tracks when sync2 holds a real post-reset sample; an edge is only
  // accepted after a genuine low has been observed, so a tick that is
  // already high when reset releases is ignored until it falls and rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      vld1_q     <= 1'b0;
      vld2_q     <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      sync1_q <= tick_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      vld1_q  <= 1'b1;
      vld2_q  <= vld1_q;
      if (vld2_q && !sync2_q) begin
        seen_low_q <= 1'b1;
      end
    end
  end

  assign tick_edge_c = sync2_q & ~prev_q & seen_low_q;

endmodule : sync_edge_detect

// File: rtl/tick_period_monitor.sv
// Measures the interval between rising edges of a slow tick, checks it
// against an expected period, raises a lock flag after a run of good
// periods and strobes an error when ticks stop.
// Ports:
//   clock        in  system clock
//   reset        in  asynchronous active-high reset
//   tick_in      in  asynchronous tick pulse
//   period       out last measured period in clock cycles
//   period_valid out one-cycle strobe when period updates
//   locked       out tick stream within tolerance
//   timeout_err  out one-cycle strobe on tick loss
module tick_period_monitor
  import tick_period_monitor_pkg::*;
#(
  parameter int unsigned W          = DEF_W,
  parameter int unsigned EXPECTED   = DEF_EXPECTED,
  parameter int unsigned TOL        = DEF_TOL,
  parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         tick_in,
  output logic [W-1:0] period,
  output logic         period_valid,
  output logic         locked,
  output logic         timeout_err
);

  localparam int unsigned TOL_LO = (EXPECTED > TOL) ? EXPECTED - TOL : 0;
  localparam int unsigned TOL_HI = EXPECTED + TOL;

  logic tick_edge_c;

  sync_edge_detect u_sync (
    .clock       (clock),
    .reset       (reset),
    .tick_in     (tick_in),
    .tick_edge_c (tick_edge_c)
  );

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [3:0]   mcnt_q, mcnt_d;
  logic [W-1:0] period_q, period_d;
  logic         period_valid_q, period_valid_d;
  logic         locked_q, locked_d;
  logic         timeout_err_q, timeout_err_d;

  // One extra bit so cnt+1 never wraps before the tolerance compare.
  logic [W:0]   meas_c;
  logic         in_tol_c;
  logic         timeout_hit_c;
  logic [3:0]   mcnt_inc_c;

  assign meas_c        = {1'b0, cnt_q} + (W+1)'(1);
  assign in_tol_c      = (meas_c >= (W+1)'(TOL_LO)) && (meas_c <= (W+1)'(TOL_HI));
  assign timeout_hit_c = (cnt_q == W'(TIMEOUT - 1));
  assign mcnt_inc_c    = mcnt_q + 4'd1;

  // Cycles since the last edge, saturating.
  always_comb begin
    cnt_d = cnt_q;
    if (tick_edge_c) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // FSM next state and output next values; an edge takes priority over timeout.
  always_comb begin
    state_d        = state_q;
    mcnt_d         = mcnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    timeout_err_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tick_edge_c) begin
          state_d = ST_MEASURE;
          mcnt_d  = 4'd0;
        end
      end
      ST_MEASURE: begin
        if (tick_edge_c) begin
          period_d       = meas_c[W-1:0];
          period_valid_d = 1'b1;
          if (in_tol_c) begin
            mcnt_d = mcnt_inc_c;
            if (mcnt_inc_c == 4'(LOCK_COUNT)) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            mcnt_d = 4'd0;
          end
        end else if (timeout_hit_c) begin
          timeout_err_d = 1'b1;
          locked_d      = 1'b0;
          mcnt_d        = 4'd0;
          state_d       = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (tick_edge_c) begin
          period_d       = meas_c[W-1:0];
          period_valid_d = 1'b1;
          if (!in_tol_c) begin
            locked_d = 1'b0;
            mcnt_d   = 4'd0;
            state_d  = ST_MEASURE;
          end
        end else if (timeout_hit_c) begin
          timeout_err_d = 1'b1;
          locked_d      = 1'b0;
          mcnt_d        = 4'd0;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        mcnt_d   = 4'd0;
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      mcnt_q         <= 4'd0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mcnt_q         <= mcnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign timeout_err  = timeout_err_q;

endmodule : tick_period_monitor

// File: tb/tb_tick_period_monitor.sv
// Randomized bench for tick_period_monitor with a timestamp-based model.
module tb_tick_period_monitor;

  localparam int EXP   = 500;
  localparam int TOLV  = 2;
  localparam int LOCKN = 4;
  localparam int TMO   = 1000;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick_in = 1'b0;
  logic [9:0] period;
  logic       period_valid;
  logic       locked;
  logic       timeout_err;

  always #5 clock = ~clock;

  tick_period_monitor dut (
    .clock        (clock),
    .reset        (reset),
    .tick_in      (tick_in),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout_err  (timeout_err)
  );

  int nvec = 0;
  int nerr = 0;

  // Model: tick samples taken since reset release, time of last edge,
  // run length of good periods and expected outputs.
  logic       samp[$];
  bit         armed;
  int         last_m;
  int         run;
  int         m = 0;
  logic [9:0] e_period;
  logic       e_pv, e_locked, e_to;

  function automatic logic [12:0] obs();
    return {period, period_valid, locked, timeout_err};
  endfunction

  function automatic logic [12:0] expv();
    return {e_period, e_pv, e_locked, e_to};
  endfunction

  task automatic model_reset();
    samp.delete();
    armed = 0; run = 0;
    e_period = '0; e_pv = 0; e_locked = 0; e_to = 0;
  endtask

  // Drive one cycle of tick, then advance the model to what should be visible.
  task automatic step(input logic t);
    logic e;
    int   s, p;
    bit   good;
    @(negedge clock);
    tick_in = t;
    @(posedge clock);
    #1;
    m++;
    samp.push_back(t);
    if (samp.size() > 8) void'(samp.pop_front());
    s = samp.size();
    // A rise seen by the synchronizer shows up two samples later.
    e = (s >= 4) && samp[s-3] && !samp[s-4];
    e_pv = 0;
    e_to = 0;
    if (armed) begin
      if (e) begin
        p = m - last_m;
        e_period = 10'(p);
        e_pv = 1;
        good = (p >= EXP - TOLV) && (p <= EXP + TOLV);
        if (!e_locked) begin
          run = good ? run + 1 : 0;
          if (run == LOCKN) e_locked = 1;
        end else if (!good) begin
          e_locked = 0;
          run = 0;
        end
        last_m = m;
      end else if (m - last_m == TMO) begin
        e_to = 1;
        armed = 0;
        e_locked = 0;
      end
    end else if (e) begin
      armed = 1;
      run = 0;
      last_m = m;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2 reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    nvec++;
    if (obs() !== 13'd0) begin
      nerr++; $display("FAIL reset_async: got %h want %h", obs(), 13'd0);
    end
    model_reset();
    @(posedge clock);
    #1;
    nvec++;
    if (obs() !== 13'd0) begin
      nerr++; $display("FAIL reset_held: got %h want %h", obs(), 13'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      nvec++;
      if (obs() !== expv()) begin
        nerr++; $display("FAIL reset_idle c=%0d: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_divider();
    int npv = 0;
    int lock_k = -1;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 500; c++) begin
        step(c == 0);
        nvec++;
        if (obs() !== expv()) begin
          nerr++; $display("FAIL divider k=%0d c=%0d: got %h want %h", k, c, obs(), expv());
        end
        if (period_valid) npv++;
        if (locked && lock_k < 0) lock_k = k;
      end
    end
    nvec++;
    if (npv !== 7) begin
      nerr++; $display("FAIL divider_strobes: got %0d want 7", npv);
    end
    nvec++;
    if (lock_k !== 4) begin
      nerr++; $display("FAIL divider_lock_tick: got %0d want 4", lock_k);
    end
  endtask

  task automatic test_tolerance();
    int lens[12];
    do_reset();
    idle(5);
    for (int i = 0; i < 12; i++) lens[i] = ($urandom_range(0, 1) != 0) ? 502 : 498;
    lens[6] = 503;
    for (int k = 0; k < 12; k++) begin
      for (int c = 0; c < lens[k]; c++) begin
        step(c == 0);
        nvec++;
        if (obs() !== expv()) begin
          nerr++; $display("FAIL tolerance k=%0d c=%0d: got %h want %h", k, c, obs(), expv());
        end
        if (k == 5 && c == 3) begin
          nvec++;
          if (locked !== 1'b1) begin
            nerr++; $display("FAIL tol_locked_5: got %b want 1", locked);
          end
        end
        if (k == 7 && c == 3) begin
          nvec++;
          if (locked !== 1'b0) begin
            nerr++; $display("FAIL tol_drop_503: got %b want 0", locked);
          end
        end
      end
    end
    nvec++;
    if (locked !== 1'b1) begin
      nerr++; $display("FAIL tol_relock: got %b want 1", locked);
    end
  endtask

  task automatic test_tick_loss();
    int nto = 0;
    int to_at = -1;
    int npv = 0;
    for (int c = 0; c <= 1100; c++) begin
      step(c == 0);
      nvec++;
      if (obs() !== expv()) begin
        nerr++; $display("FAIL loss c=%0d: got %h want %h", c, obs(), expv());
      end
      if (timeout_err) begin nto++; to_at = c; end
    end
    nvec++;
    if (nto !== 1 || to_at !== 1002) begin
      nerr++; $display("FAIL loss_timeout: got count %0d at %0d want 1 at 1002", nto, to_at);
    end
    nvec++;
    if (locked !== 1'b0) begin
      nerr++; $display("FAIL loss_unlock: got %b want 0", locked);
    end
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 500; c++) begin
        step(c == 0);
        nvec++;
        if (obs() !== expv()) begin
          nerr++; $display("FAIL loss_recover k=%0d c=%0d: got %h want %h", k, c, obs(), expv());
        end
        if (period_valid) npv++;
      end
    end
    nvec++;
    if (npv !== 2) begin
      nerr++; $display("FAIL loss_first_no_strobe: got %0d want 2", npv);
    end
  endtask

  task automatic test_race();
    int nto = 0;
    int len;
    for (int k = 0; k < 7; k++) begin
      len = (k < 5) ? 500 : ((k == 5) ? 1000 : 20);
      for (int c = 0; c < len; c++) begin
        step(c == 0);
        nvec++;
        if (obs() !== expv()) begin
          nerr++; $display("FAIL race k=%0d c=%0d: got %h want %h", k, c, obs(), expv());
        end
        if (timeout_err) nto++;
        if (k == 5 && c == 3) begin
          nvec++;
          if (locked !== 1'b1) begin
            nerr++; $display("FAIL race_prelock: got %b want 1", locked);
          end
        end
        if (k == 6 && c == 2) begin
          nvec++;
          if ({period, period_valid, timeout_err, locked} !== {10'd1000, 1'b1, 1'b0, 1'b0}) begin
            nerr++; $display("FAIL race_strobe: got p=%0d v=%b to=%b l=%b want p=1000 v=1 to=0 l=0",
                             period, period_valid, timeout_err, locked);
          end
        end
      end
    end
    nvec++;
    if (nto !== 0) begin
      nerr++; $display("FAIL race_no_timeout: got %0d want 0", nto);
    end
  endtask

  task automatic test_reset_mid();
    int lock_k = -1;
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 500; c++) begin
        step(c == 0);
        nvec++;
        if (obs() !== expv()) begin
          nerr++; $display("FAIL mid_prep k=%0d c=%0d: got %h want %h", k, c, obs(), expv());
        end
        if (k == 5 && c == 250) break;
      end
    end
    nvec++;
    if (locked !== 1'b1) begin
      nerr++; $display("FAIL mid_locked_before: got %b want 1", locked);
    end
    #2 reset = 1'b1;
    tick_in = 1'b1;
    #1;
    nvec++;
    if (obs() !== 13'd0) begin
      nerr++; $display("FAIL mid_async_clear: got %h want %h", obs(), 13'd0);
    end
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(i < 10);
      nvec++;
      if (obs() !== expv()) begin
        nerr++; $display("FAIL mid_held_tick i=%0d: got %h want %h", i, obs(), expv());
      end
    end
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 500; c++) begin
        step(c == 0);
        nvec++;
        if (obs() !== expv()) begin
          nerr++; $display("FAIL mid_relock k=%0d c=%0d: got %h want %h", k, c, obs(), expv());
        end
        if (locked && lock_k < 0) lock_k = k;
      end
    end
    nvec++;
    if (lock_k !== 4) begin
      nerr++; $display("FAIL mid_fresh_lock: got %0d want 4", lock_k);
    end
  endtask

  task automatic test_wide();
    int npv = 0;
    int w;
    for (int k = 0; k < 7; k++) begin
      w = (k == 0) ? 3 : int'($urandom_range(2, 5));
      for (int c = 0; c < 500; c++) begin
        step(c < w);
        nvec++;
        if (obs() !== expv()) begin
          nerr++; $display("FAIL wide k=%0d c=%0d: got %h want %h", k, c, obs(), expv());
        end
        if (period_valid) begin
          npv++;
          nvec++;
          if (period !== 10'd500) begin
            nerr++; $display("FAIL wide_period: got %0d want 500", period);
          end
        end
      end
    end
    nvec++;
    if (npv !== 7) begin
      nerr++; $display("FAIL wide_single_edge: got %0d want 7", npv);
    end
  endtask

  task automatic test_random();
    int len, w, r;
    for (int k = 0; k < 30; k++) begin
      r = int'($urandom_range(0, 9));
      len = (r == 0) ? 1100 : ((r == 1) ? 1000 : int'($urandom_range(495, 505)));
      w = int'($urandom_range(1, 4));
      for (int c = 0; c < len; c++) begin
        step(c < w);
        nvec++;
        if (obs() !== expv()) begin
          nerr++; $display("FAIL random k=%0d c=%0d: got %h want %h", k, c, obs(), expv());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_tolerance();
    test_tick_loss();
    test_race();
    test_reset_mid();
    test_wide();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule : tb_tick_period_monitor

// File: doc/tick_period_monitor.md
# tick_period_monitor

Receiving-end checker for the slow tick produced by the clock-divider chain. It samples a one-cycle tick pulse train on the fast system clock and measures the interval between successive rising edges in clock cycles. It compares each interval against an expected period and raises a lock flag after a run of in-tolerance periods, plus an error pulse if ticks stop. It sits beside the divider in FPGA builds as a self-check for divider output and for any pulse stream derived from it.

## Interface
- W, 10, width of period counter and period output
- EXPECTED, 500, nominal tick period in clock cycles
- TOL, 2, allowed absolute deviation from EXPECTED (inclusive)
- LOCK_COUNT, 4, consecutive in-tolerance periods required to assert locked; range 1..15
- TIMEOUT, 1000, cycles without an edge before timeout; must be < 2^W-1 and > EXPECTED+TOL
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately
- tick_in  in  1  tick pulse (≥1 cycle high), treated as asynchronous
- period  out  W  last measured period; reset 0
- period_valid  out  1  one-cycle strobe when period updates; reset 0
- locked  out  1  level, tick stream within tolerance; reset 0
- timeout_err  out  1  one-cycle strobe on tick loss; reset 0

## Operation
- Input path: tick_in → two-flop synchronizer → previous-value register; edge = sync & ~prev.
- Counter cnt (W bits): cleared on reset; on edge cnt ← 0; otherwise cnt ← cnt+1, saturating at 2^W-1.
- FSM states: IDLE, MEASURE, LOCKED. Match counter mcnt (4 bits).
- IDLE: waits for first edge; on edge → MEASURE, mcnt ← 0. No period_valid is produced, because the first edge has no reference edge.
- MEASURE/LOCKED, on edge:
  - period ← cnt+1 and period_valid = 1.
  - A period is in-tolerance when |(cnt+1) − EXPECTED| ≤ TOL. Compute with W+1-bit signed or unsigned-compare logic, with no wrap.
  - MEASURE, in-tolerance: mcnt ← mcnt+1. When mcnt+1 == LOCK_COUNT → LOCKED and locked ← 1.
  - MEASURE, out-of-tolerance: mcnt ← 0 and stay in MEASURE.
  - LOCKED, in-tolerance: stay in LOCKED.
  - LOCKED, out-of-tolerance: locked ← 0, mcnt ← 0, → MEASURE.
- Timeout: in MEASURE or LOCKED with no edge while cnt == TIMEOUT−1 → timeout_err = 1 for one cycle, locked ← 0, mcnt ← 0, → IDLE. No timeout is checked in IDLE.
- Simultaneous edge and timeout condition: the edge wins and no timeout_err is raised.
- Saturated cnt is unreachable outside IDLE given the TIMEOUT constraint. In IDLE, cnt saturates harmlessly.

## Timing
- Edge detect latency: tick_in rising edge sampled at clock edge k → edge asserted in cycle k+2.
- period, period_valid and the locked transition all register on the clock edge ending the edge cycle. period_valid is high one cycle later, coincident with the new period.
- Periodic ticks every P cycles → period = P exactly, since the fixed synchronizer delay cancels.
- Lock time from first tick: LOCK_COUNT+1 edges. With defaults, locked rises with the period_valid of the 5th tick.
- reset asserted at any time: all outputs go to 0 asynchronously, FSM → IDLE, synchronizer flops → 0. After release, a tick already high is not seen as an edge until it falls and rises again.

## Structure
- Shared package: FSM state enum (IDLE, MEASURE, LOCKED) and default parameter constants (W, EXPECTED, TOL, LOCK_COUNT, TIMEOUT).
- One sub-module, sync_edge_detect: two-flop synchronizer plus rising-edge pulse, with clock and async active-high reset.
- Top level holds the counter, tolerance compare, FSM and output registers.

## Test plan
- Divider-pattern stream: one-cycle ticks every 500 cycles → period = 500 with period_valid on ticks 2..n; locked = 1 with the 5th tick's strobe.
- Tolerance edges: periods of 498 and 502 → locked after 5 ticks. Period 503 once while LOCKED → locked drops with that strobe, then relocks after 4 more good periods.
- Tick loss: locked stream, then ticks stop → timeout_err pulse exactly 1000 cycles after the last detected edge; locked = 0; the next tick produces no period_valid.
- Race: next tick edge lands on the cycle where cnt == 999 → period = 1000 strobe, no timeout_err. Check the tolerance result is "out" with the default parameters.
- Reset mid-operation: assert reset while LOCKED and mid-count → period, period_valid, locked and timeout_err all 0 before the next clock edge. After release, lock requires a fresh 5 ticks.
- Wide pulses: ticks 3 cycles high, every 500 cycles → a single edge per tick and period = 500.
